// File: rtl/ctrl_sigs.sv
// ctrl_sigs: shared types and helpers for the dispatch controller.
//   exut_t      - execution unit selector (alu, jmp, mem, mul); indexes the
//                 one-hot issue-queue request vector.
//   state_t     - dispatch FSM states.
//   SHADOW_MAX_DEFAULT - default upper bound on the length of a branch shadow.
//   shadow_len  - number of instructions a forward branch would shadow, or 0
//                 when the branch does not qualify for shadow execution.
package ctrl_sigs;

    localparam int SHADOW_MAX_DEFAULT = 3;

    typedef enum logic [1:0] {
        EXUT_ALU = 2'd0,
        EXUT_JMP = 2'd1,
        EXUT_MEM = 2'd2,
        EXUT_MUL = 2'd3
    } exut_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHADOW = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // A forward branch skipping over k whole instructions lands at
    // pc + 4*(k+1); the shadow covers exactly those k instructions.
    function automatic logic [31:0] shadow_len(input logic [31:0] pc,
                                               input logic [31:0] target,
                                               input int          max_len);
        logic [31:0] diff;
        diff = target - pc;
        if (target > pc && diff[1:0] == 2'b00 &&
            diff[31:2] >= 30'd2 && diff[31:2] <= 30'(max_len + 1))
            return {2'b00, diff[31:2]} - 32'd1;
        return 32'd0;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo: small in-order buffer between the fetch queue and decode.
//   clk, rst    - clock and synchronous active-high reset (control only)
//   clear       - discard all entries on the next edge
//   push, wdata - write one entry (caller guarantees not full)
//   pop         - retire the head entry (caller guarantees not empty)
//   rdata       - head entry
//   empty, full - occupancy flags
module dispatch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: buffers fetched instructions, presents the head to decode,
// dispatches it to the issue queue of its execution unit, and runs the
// forward-branch shadow / illegal-instruction halt FSM.
//   clk, rst                 - clock, synchronous active-high reset
//   fq_valid/fq_instr/fq_pc  - fetch queue offer; fq_ready accepts it
//   flush                    - backend redirect, discards all held state
//   dec_instr                - head instruction to the decoder
//   dec_legal/dec_exut/dec_br/dec_shadowable/dec_btarget - decode results
//   under_shadow             - shadow active, fed back to the decoder
//   iq_valid/iq_ready        - one-hot dispatch request / per-unit ready
//   out_instr/out_pc/out_shadowed - dispatched instruction and predication
//   illegal_valid/illegal_pc - one-cycle illegal-instruction report
module dispatch_ctrl
    import ctrl_sigs::*;
#(
    parameter int SHADOW_MAX = SHADOW_MAX_DEFAULT,
    parameter int DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fq_valid,
    input  logic [31:0] fq_instr,
    input  logic [31:0] fq_pc,
    output logic        fq_ready,
    input  logic        flush,
    output logic [31:0] dec_instr,
    input  logic        dec_legal,
    input  logic [1:0]  dec_exut,
    input  logic        dec_br,
    input  logic        dec_shadowable,
    input  logic [31:0] dec_btarget,
    output logic        under_shadow,
    output logic [3:0]  iq_valid,
    input  logic [3:0]  iq_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_shadowed,
    output logic        illegal_valid,
    output logic [31:0] illegal_pc
);

    localparam int CW = $clog2(SHADOW_MAX + 1);

    state_t        state;
    logic [CW-1:0] shadow_cnt;

    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        blocked;
    logic        present;
    logic        want_dispatch;
    logic        fire;
    logic        cancel;
    logic [31:0] slen;
    logic        br_ok;
    exut_t       exut;

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .wdata ({fq_instr, fq_pc}),
        .pop   (pop),
        .rdata ({head_instr, head_pc}),
        .empty (empty),
        .full  (full)
    );

    assign exut = exut_t'(dec_exut);

    // Reset and flush silence every request in the cycle they are seen.
    assign blocked       = rst | flush | (state == ST_HALT);
    assign present       = ~empty & ~blocked;
    assign want_dispatch = present & dec_legal;
    assign fire          = want_dispatch & iq_ready[exut];

    assign iq_valid      = want_dispatch ? (4'b0001 << exut) : 4'b0000;
    assign illegal_valid = present & ~dec_legal;
    assign illegal_pc    = head_pc;
    assign pop           = fire | illegal_valid;

    assign fq_ready      = ~full & ~blocked;
    assign push          = fq_valid & fq_ready;

    assign dec_instr     = head_instr;
    assign out_instr     = head_instr;
    assign out_pc        = head_pc;

    // A non-shadowable head ends the shadow as soon as it is presented, so
    // it always leaves unpredicated.
    assign cancel        = (state == ST_SHADOW) & want_dispatch & ~dec_shadowable;
    assign out_shadowed  = (state == ST_SHADOW) & present & dec_shadowable;
    assign under_shadow  = (state == ST_SHADOW);

    assign slen          = shadow_len(head_pc, dec_btarget, SHADOW_MAX);
    assign br_ok         = dec_br & (slen != 32'd0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= ST_IDLE;
            shadow_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (illegal_valid) begin
                        state <= ST_HALT;
                    end else if (fire && br_ok) begin
                        state      <= ST_SHADOW;
                        shadow_cnt <= CW'(slen);
                    end
                end
                ST_SHADOW: begin
                    if (illegal_valid) begin
                        state      <= ST_HALT;
                        shadow_cnt <= '0;
                    end else if (cancel) begin
                        state      <= ST_IDLE;
                        shadow_cnt <= '0;
                    end else if (fire) begin
                        shadow_cnt <= shadow_cnt - 1'b1;
                        if (shadow_cnt == CW'(1)) state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state      <= ST_IDLE;
                    shadow_cnt <= '0;
                end
            endcase
        end
    end

endmodule
